// File: rtl/cdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdu_pkg
// Brief    : Shared width helpers and step encoding for the CDU read-counter bank
// Revision : 1.0  initial release
// ============================================================================
package cdu_pkg;

    // Signed pending accumulator width able to hold +/-max_pending
    function automatic int calc_pend_w(input int max_pending);
        return $clog2(max_pending + 1) + 1;
    endfunction

    function automatic int calc_slot_w(input int pulse_div);
        return (pulse_div > 1) ? $clog2(pulse_div) : 1;
    endfunction

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DN   = 2'b10
    } step_e;

endpackage
`default_nettype wire

// File: rtl/cdu_rc_axis.sv
`default_nettype none
// ============================================================================
// Module   : cdu_rc_axis
// Brief    : One CDU axis - pending accumulator, saturation, overflow flag,
//            angle register and rate-limited AGC pulse outputs
// Revision : 1.0  initial release
// ============================================================================
module cdu_rc_axis
    import cdu_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int MAX_PENDING = 7
) (
    input  logic             CLOCKH,
    input  logic             rst_n,
    input  logic             i_slot_tick,
    input  logic             i_inc_up,
    input  logic             i_inc_dn,
    input  logic             i_zero,
    input  logic             i_rate_sel,
    input  logic             i_ovf_clr,
    output logic [WIDTH-1:0] o_angle,
    output logic             o_plus,
    output logic             o_minus,
    output logic             o_ovf
);

    localparam int c_pend_w = calc_pend_w(MAX_PENDING);
    localparam int c_sum_w  = c_pend_w + 1;
    localparam logic signed [c_sum_w-1:0] c_max_pos = c_sum_w'(MAX_PENDING);
    localparam logic signed [c_sum_w-1:0] c_max_neg = -c_max_pos;
    localparam logic signed [c_sum_w-1:0] c_one     = c_sum_w'(1);
    localparam logic [WIDTH-1:0]          c_lsb     = WIDTH'(1);

    logic signed [c_pend_w-1:0] r_pending;
    logic [WIDTH-1:0]           r_angle;
    logic                       r_plus;
    logic                       r_minus;
    logic                       r_ovf;

    step_e                      w_step;
    logic                       w_emit;
    logic                       w_drop;
    logic signed [c_sum_w-1:0]  w_after_emit;
    logic signed [c_sum_w-1:0]  w_inc;
    logic signed [c_sum_w-1:0]  w_sum;
    logic signed [c_pend_w-1:0] w_pending_next;

    // The emit step is removed first, so a same-edge strobe only overflows
    // when the accumulator was already pinned at the limit.
    always_comb begin
        w_emit = (i_rate_sel | i_slot_tick) && (r_pending != '0);
        w_step = STEP_NONE;
        if (w_emit) begin
            w_step = r_pending[c_pend_w-1] ? STEP_DN : STEP_UP;
        end

        w_after_emit = {r_pending[c_pend_w-1], r_pending};
        case (w_step)
            STEP_UP: w_after_emit = {r_pending[c_pend_w-1], r_pending} - c_one;
            STEP_DN: w_after_emit = {r_pending[c_pend_w-1], r_pending} + c_one;
            default: w_after_emit = {r_pending[c_pend_w-1], r_pending};
        endcase

        w_inc = '0;
        if (i_inc_up && !i_inc_dn) begin
            w_inc = c_one;
        end else if (i_inc_dn && !i_inc_up) begin
            w_inc = '1;
        end

        w_sum          = w_after_emit + w_inc;
        w_drop         = (w_sum > c_max_pos) || (w_sum < c_max_neg);
        w_pending_next = w_drop ? w_after_emit[c_pend_w-1:0] : w_sum[c_pend_w-1:0];
    end

    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_angle   <= '0;
            r_plus    <= 1'b0;
            r_minus   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_drop && !i_zero) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if (i_zero) begin
                r_pending <= '0;
                r_angle   <= '0;
                r_plus    <= 1'b0;
                r_minus   <= 1'b0;
            end else begin
                r_pending <= w_pending_next;
                r_plus    <= (w_step == STEP_UP);
                r_minus   <= (w_step == STEP_DN);
                case (w_step)
                    STEP_UP: r_angle <= r_angle + c_lsb;
                    STEP_DN: r_angle <= r_angle - c_lsb;
                    default: r_angle <= r_angle;
                endcase
            end
        end
    end

    assign o_angle = r_angle;
    assign o_plus  = r_plus;
    assign o_minus = r_minus;
    assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/cdu_read_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : cdu_read_counter_bank
// Brief    : Multi-axis CDU read-counter bank with shared pulse-slot divider
// Revision : 1.0  initial release
// ============================================================================
module cdu_read_counter_bank
    import cdu_pkg::*;
#(
    parameter int NUM_AXES    = 3,
    parameter int WIDTH       = 16,
    parameter int PULSE_DIV   = 8,
    parameter int MAX_PENDING = 7
) (
    input  logic                      CLOCKH,
    input  logic                      rst_n,
    input  logic [NUM_AXES-1:0]       inc_up,
    input  logic [NUM_AXES-1:0]       inc_dn,
    input  logic [NUM_AXES-1:0]       zero_cdu,
    input  logic [NUM_AXES-1:0]       rate_sel,
    input  logic [NUM_AXES-1:0]       ovf_clr,
    output logic [NUM_AXES*WIDTH-1:0] angle,
    output logic [NUM_AXES-1:0]       agc_plus,
    output logic [NUM_AXES-1:0]       agc_minus,
    output logic [NUM_AXES-1:0]       pend_ovf
);

    localparam int                  c_slot_w    = calc_slot_w(PULSE_DIV);
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(PULSE_DIV - 1);
    localparam logic [c_slot_w-1:0] c_slot_one  = c_slot_w'(1);

    logic [c_slot_w-1:0] r_slot_cnt;
    logic                w_slot_tick;

    assign w_slot_tick = (r_slot_cnt == c_slot_last);

    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
        end else if (w_slot_tick) begin
            r_slot_cnt <= '0;
        end else begin
            r_slot_cnt <= r_slot_cnt + c_slot_one;
        end
    end

    for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
        cdu_rc_axis #(
            .WIDTH       (WIDTH),
            .MAX_PENDING (MAX_PENDING)
        ) u_axis (
            .CLOCKH      (CLOCKH),
            .rst_n       (rst_n),
            .i_slot_tick (w_slot_tick),
            .i_inc_up    (inc_up[gi]),
            .i_inc_dn    (inc_dn[gi]),
            .i_zero      (zero_cdu[gi]),
            .i_rate_sel  (rate_sel[gi]),
            .i_ovf_clr   (ovf_clr[gi]),
            .o_angle     (angle[gi*WIDTH +: WIDTH]),
            .o_plus      (agc_plus[gi]),
            .o_minus     (agc_minus[gi]),
            .o_ovf       (pend_ovf[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_cdu_read_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdu_read_counter_bank
// Brief    : Directed self-checking bench for cdu_read_counter_bank
// Revision : 1.0  initial release
// ============================================================================
module tb_cdu_read_counter_bank;

    localparam int NUM_AXES    = 3;
    localparam int WIDTH       = 16;
    localparam int PULSE_DIV   = 8;
    localparam int MAX_PENDING = 7;

    logic                      CLOCKH = 1'b0;
    logic                      rst_n;
    logic [NUM_AXES-1:0]       inc_up;
    logic [NUM_AXES-1:0]       inc_dn;
    logic [NUM_AXES-1:0]       zero_cdu;
    logic [NUM_AXES-1:0]       rate_sel;
    logic [NUM_AXES-1:0]       ovf_clr;
    logic [NUM_AXES*WIDTH-1:0] angle;
    logic [NUM_AXES-1:0]       agc_plus;
    logic [NUM_AXES-1:0]       agc_minus;
    logic [NUM_AXES-1:0]       pend_ovf;

    int tests  = 0;
    int fails  = 0;
    int edge_n = 0;
    int npulse;
    int nminus;

    always #5 CLOCKH = ~CLOCKH;

    cdu_read_counter_bank #(
        .NUM_AXES    (NUM_AXES),
        .WIDTH       (WIDTH),
        .PULSE_DIV   (PULSE_DIV),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .CLOCKH    (CLOCKH),
        .rst_n     (rst_n),
        .inc_up    (inc_up),
        .inc_dn    (inc_dn),
        .zero_cdu  (zero_cdu),
        .rate_sel  (rate_sel),
        .ovf_clr   (ovf_clr),
        .angle     (angle),
        .agc_plus  (agc_plus),
        .agc_minus (agc_minus),
        .pend_ovf  (pend_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ang(input int i);
        return angle[i*WIDTH +: WIDTH];
    endfunction

    // Advance one edge; sample and drive 1 time unit after it
    task automatic cyc();
        @(posedge CLOCKH);
        #1;
        edge_n++;
    endtask

    initial begin
        rst_n    = 1'b0;
        inc_up   = '0;
        inc_dn   = '0;
        zero_cdu = '0;
        rate_sel = '0;
        ovf_clr  = '0;
        repeat (3) @(posedge CLOCKH);
        #1;
        check("rst_angle", 64'(angle), 64'h0);
        check("rst_plus",  64'(agc_plus), 64'h0);
        check("rst_minus", 64'(agc_minus), 64'h0);
        check("rst_ovf",   64'(pend_ovf), 64'h0);
        rst_n  = 1'b1;
        edge_n = 0;

        // Fine-rate single increment: strobe on edge 2, pulse after edge 7
        cyc();
        cyc();
        inc_up[0] = 1'b1;
        cyc();
        inc_up[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("fine_wait_plus0", 64'(agc_plus[0]), 64'h0);
        end
        cyc();
        check("fine_plus0",  64'(agc_plus[0]), 64'h1);
        check("fine_angle0", 64'(ang(0)), 64'h1);
        cyc();
        check("fine_plus0_drop", 64'(agc_plus[0]), 64'h0);
        check("fine_minus0",     64'(agc_minus[0]), 64'h0);
        check("fine_angle1",     64'(ang(1)), 64'h0);
        check("fine_angle2",     64'(ang(2)), 64'h0);

        // Coarse-rate down burst on axis 1
        rate_sel[1] = 1'b1;
        inc_dn[1]   = 1'b1;
        nminus      = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            nminus += int'(agc_minus[1]);
            check("coarse_minus1_burst", 64'(agc_minus[1]), (i >= 1) ? 64'h1 : 64'h0);
        end
        inc_dn[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            nminus += int'(agc_minus[1]);
            check("coarse_minus1_tail", 64'(agc_minus[1]), (i == 0) ? 64'h1 : 64'h0);
            check("coarse_plus1", 64'(agc_plus[1]), 64'h0);
        end
        check("coarse_minus_count", 64'(nminus), 64'd5);
        check("coarse_angle1", 64'(ang(1)), 64'hFFFB);
        check("coarse_ovf1",   64'(pend_ovf[1]), 64'h0);

        // Saturation on axis 2: burst spans exactly one slot tick
        while (edge_n % PULSE_DIV != 3) cyc();
        inc_up[2] = 1'b1;
        npulse    = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            npulse += int'(agc_plus[2]);
        end
        inc_up[2] = 1'b0;
        check("sat_ovf2_set",    64'(pend_ovf[2]), 64'h1);
        check("sat_mid_pulses",  64'(npulse), 64'd1);
        for (int i = 0; i < 62; i++) begin
            cyc();
            npulse += int'(agc_plus[2]);
        end
        check("sat_total_pulses", 64'(npulse), 64'd8);
        check("sat_angle2",       64'(ang(2)), 64'h8);
        check("sat_ovf2_sticky",  64'(pend_ovf[2]), 64'h1);
        ovf_clr[2] = 1'b1;
        cyc();
        ovf_clr[2] = 1'b0;
        check("sat_ovf2_clr", 64'(pend_ovf[2]), 64'h0);

        // Simultaneous up/down cancel on axis 0
        inc_up[0] = 1'b1;
        inc_dn[0] = 1'b1;
        npulse    = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            npulse += int'(agc_plus[0]) + int'(agc_minus[0]);
        end
        inc_up[0] = 1'b0;
        inc_dn[0] = 1'b0;
        repeat (10) begin
            cyc();
            npulse += int'(agc_plus[0]) + int'(agc_minus[0]);
        end
        check("cancel_pulses", 64'(npulse), 64'd0);
        check("cancel_angle0", 64'(ang(0)), 64'h1);
        check("cancel_ovf0",   64'(pend_ovf[0]), 64'h0);

        // Wrap: clear axis 0, preload to all-ones at coarse rate, then +1
        zero_cdu[0] = 1'b1;
        cyc();
        zero_cdu[0] = 1'b0;
        check("wrap_zeroed", 64'(ang(0)), 64'h0);
        rate_sel[0] = 1'b1;
        inc_up[0]   = 1'b1;
        repeat (65535) cyc();
        inc_up[0] = 1'b0;
        cyc();
        check("wrap_preload", 64'(ang(0)), 64'hFFFF);
        check("wrap_preload_plus", 64'(agc_plus[0]), 64'h1);
        check("wrap_preload_ovf",  64'(pend_ovf[0]), 64'h0);
        cyc();
        check("wrap_idle_plus", 64'(agc_plus[0]), 64'h0);
        inc_up[0] = 1'b1;
        cyc();
        inc_up[0] = 1'b0;
        check("wrap_hold", 64'(ang(0)), 64'hFFFF);
        cyc();
        check("wrap_angle0", 64'(ang(0)), 64'h0);
        check("wrap_plus0",  64'(agc_plus[0]), 64'h1);

        // zero_cdu with pending = +4 on axis 1 (fine rate, no tick in between)
        rate_sel[1] = 1'b0;
        while (edge_n % PULSE_DIV != 0) cyc();
        inc_up[1] = 1'b1;
        npulse    = 0;
        repeat (4) begin
            cyc();
            npulse += int'(agc_plus[1]) + int'(agc_minus[1]);
        end
        inc_up[1] = 1'b0;
        check("zero_pre_angle1", 64'(ang(1)), 64'hFFFB);
        zero_cdu[1] = 1'b1;
        repeat (3) begin
            cyc();
            npulse += int'(agc_plus[1]) + int'(agc_minus[1]);
            check("zero_during_angle1", 64'(ang(1)), 64'h0);
        end
        zero_cdu[1] = 1'b0;
        repeat (24) begin
            cyc();
            npulse += int'(agc_plus[1]) + int'(agc_minus[1]);
        end
        check("zero_pulses1", 64'(npulse), 64'd0);
        check("zero_after_angle1", 64'(ang(1)), 64'h0);

        // Asynchronous reset while a pulse is high
        rate_sel[2] = 1'b1;
        inc_up[2]   = 1'b1;
        cyc();
        inc_up[2] = 1'b0;
        cyc();
        check("areset_pre_plus2", 64'(agc_plus[2]), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_angle", 64'(angle), 64'h0);
        check("areset_plus",  64'(agc_plus), 64'h0);
        check("areset_minus", 64'(agc_minus), 64'h0);
        check("areset_ovf",   64'(pend_ovf), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdu_read_counter_bank.md
Name: cdu_read_counter_bank

Overview:
Parametrised multi-axis CDU read-counter bank. It accepts per-axis up/down increment strobes from the angle quantizer and buffers them in a signed pending accumulator. It meters the buffered increments out as rate-limited plus/minus pulses to the AGC, and maintains a WIDTH-bit angle register per axis. It replaces the single-axis, fixed-rate counter: axis count, width, pulse rate and buffer depth are generic, and it adds a selectable coarse-slew rate and overflow reporting.

Parameters:
NUM_AXES, 3, number of independent axes (1..8)
WIDTH, 16, angle register width; LSB = 360°/2^WIDTH
PULSE_DIV, 8, CLOCKH cycles per fine-rate pulse slot (51.2 kHz / 8 = 6.4 kpps); must be ≥2
MAX_PENDING, 7, magnitude limit of the signed pending accumulator per axis (≥1)

Ports:
CLOCKH  in  1  51.2 kHz system clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
inc_up  in  NUM_AXES  one-cycle +1 LSB request per axis
inc_dn  in  NUM_AXES  one-cycle −1 LSB request per axis
zero_cdu  in  NUM_AXES  level; clears that axis while high
rate_sel  in  NUM_AXES  0 = fine rate (one pulse per slot); 1 = coarse slew (one pulse per cycle)
ovf_clr  in  NUM_AXES  one-cycle clear of the sticky overflow flag
angle  out  NUM_AXES*WIDTH  registered angle; axis i occupies bits [i*WIDTH +: WIDTH]
agc_plus  out  NUM_AXES  one-cycle +1 pulse to AGC
agc_minus  out  NUM_AXES  one-cycle −1 pulse to AGC
pend_ovf  out  NUM_AXES  sticky flag: an increment was dropped

Behaviour:
- Reset (async assert, sync deassert by design): angle=0, pending=0, agc_plus=agc_minus=0, pend_ovf=0, slot counter=0. All outputs are registered.
- Slot divider is shared across axes and counts 0..PULSE_DIV−1 then wraps. slot_tick=1 while the count is PULSE_DIV−1, so the first tick is cycle PULSE_DIV−1 after reset release. zero_cdu does not affect the divider.
- Per axis, emit = (rate_sel ? 1 : slot_tick) and pending≠0 (the registered value).
- On an emit edge with pending>0: agc_plus=1 for one cycle, angle+=1, pending−=1.
- On an emit edge with pending<0: agc_minus=1 for one cycle, angle−=1, pending+=1.
- agc_plus and agc_minus are never both high.
- angle wraps modulo 2^WIDTH (all-ones +1 → 0, 0 −1 → all-ones). It never saturates.
- inc_up and inc_dn high in the same cycle cancel: no change and no overflow.
- net = (inc_up − inc_dn) − (emit step).
- pending_next = pending + net, evaluated after the same-edge emit step. An increment arriving on an emit edge is never lost to ordering.
- Latency: a strobe at edge k is held in pending after edge k. Its pulse appears no earlier than edge k+1 in coarse mode, and at the first slot_tick edge after k in fine mode.
- Saturation: if pending_next would exceed +MAX_PENDING or go below −MAX_PENDING, pending stays at the limit, the increment is dropped and pend_ovf is set.
- Set wins over ovf_clr in the same cycle.
- zero_cdu high: angle=0 and pending=0 on each edge; agc_plus/minus forced 0; increments ignored; pend_ovf unaffected.
- After zero_cdu deasserts, the axis resumes at the next edge.
- A rate_sel change takes effect on the next edge. Pending is preserved.
- Axes are fully independent except for the shared divider.

Decomposition:
- Package cdu_pkg holds derived constants: PEND_W = $clog2(MAX_PENDING+1)+1 (signed pending width) and SLOT_W = $clog2(PULSE_DIV).
- Put the angle-slice helper in cdu_pkg only if more than one module needs it.
- Sub-module cdu_rc_axis holds one axis: pending accumulator, saturation, overflow flag, angle register and pulse outputs. Its inputs are slot_tick and the axis controls.
- The top level holds the slot divider and a generate loop of NUM_AXES instances.

Test Plan:
- Reset release, then one inc_up on axis 0 at cycle 2 (fine rate). Expect agc_plus[0] high only in the cycle after edge 7, and angle[0]=1; other axes stay 0.
- Five inc_dn strobes on axis 1 within one slot, with rate_sel[1]=1. Expect five consecutive agc_minus[1] pulses and angle[1] going 0 → 0xFFFB; no overflow.
- Ten inc_up strobes on consecutive cycles on axis 2 (fine rate). Expect pending to saturate at 7, pend_ovf[2]=1 and exactly 8 agc_plus pulses total (one emitted mid-burst). Then ovf_clr[2] clears the flag.
- inc_up and inc_dn together on axis 0 for 20 cycles. Expect no pulses, angle unchanged and pend_ovf=0.
- Preload angle[0]=0xFFFF via 65535 coarse-rate increments, then one more inc_up. Expect the angle to wrap to 0x0000 with agc_plus asserted.
- Pending=+4 on axis 1, assert zero_cdu[1] for 3 cycles, then release. Expect angle=0, no pulses during or after, and pending=0. Also assert rst_n low mid-pulse and expect all outputs 0 immediately (asynchronously).
